// File: rtl/car_sequencer.sv
// car_sequencer: drives the active-low gate sensors SD1/SD2 through the
// four-phase pattern of one car entering (dir 0) or leaving (dir 1).
//
// Handshake: a request is accepted on any rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. req_dir and
// req_dwell are sampled only on that edge. While busy, req_valid is ignored
// and nothing is queued.
module car_sequencer #(
  parameter int DWELL_W = 16,
  parameter int GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_dir,
  input  logic [DWELL_W-1:0] req_dwell,
  output logic               req_ready,
  input  logic               abort,
  output logic               SD1,
  output logic               SD2,
  output logic               busy,
  output logic               done,
  output logic               done_dir,
  output logic               aborted
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q;
  logic               aborting;

  localparam logic [DWELL_W-1:0] GAP_LOAD = DWELL_W'(GAP_CYC - 1);

  // Sequencer FSM: state, dwell counter and all registered outputs together.
  // Phase lengths come from a down-counter that runs dwell..0, so the
  // all-ones dwell gives 2^DWELL_W cycles without ever wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell_q   <= '0;
      dir_q     <= 1'b0;
      aborting  <= 1'b0;
      SD1       <= 1'b1;
      SD2       <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_dir  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= P1;
            dir_q     <= req_dir;
            dwell_q   <= req_dwell;
            cnt       <= req_dwell;
            aborting  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            // P1: only the sensor on the approach side is covered.
            SD1       <= req_dir;
            SD2       <= ~req_dir;
          end
        end
        P1, P2, P3: begin
          if (abort) begin
            // Car backs out: release both sensors and still run a full gap.
            state    <= GAP;
            cnt      <= GAP_LOAD;
            aborting <= 1'b1;
            SD1      <= 1'b1;
            SD2      <= 1'b1;
          end else if (cnt == '0) begin
            if (state == P1) begin
              state <= P2;
              cnt   <= dwell_q;
              SD1   <= 1'b0;
              SD2   <= 1'b0;
            end else if (state == P2) begin
              state <= P3;
              cnt   <= dwell_q;
              SD1   <= ~dir_q;
              SD2   <= dir_q;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
              SD1   <= 1'b1;
              SD2   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            if (aborting) begin
              aborted <= 1'b1;
            end else begin
              done     <= 1'b1;
              done_dir <= dir_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          SD1       <= 1'b1;
          SD2       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: per-cycle sensor/status checks against
// the four-phase pattern, plus a small behavioural car detector that turns
// the sensor waveform into inc/dec counts.
module tb_car_sequencer;

  localparam int GAP_CYC = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_dir;
  logic [15:0] req_dwell;
  logic        req_ready;
  logic        abort;
  logic        SD1, SD2, busy, done, done_dir, aborted;

  // Narrow instance for the max-dwell case.
  logic        req_valid_s;
  logic [3:0]  req_dwell_s;
  logic        abort_s;
  logic        req_ready_s, SD1_s, SD2_s, busy_s, done_s, done_dir_s, aborted_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p1_start = 0;
  int inc_cnt = 0;
  int dec_cnt = 0;

  car_sequencer #(.DWELL_W(16), .GAP_CYC(GAP_CYC)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir),
    .req_dwell(req_dwell), .req_ready(req_ready), .abort(abort),
    .SD1(SD1), .SD2(SD2), .busy(busy), .done(done), .done_dir(done_dir),
    .aborted(aborted)
  );

  car_sequencer #(.DWELL_W(4), .GAP_CYC(GAP_CYC)) u_small (
    .clk(clk), .rst(rst), .req_valid(req_valid_s), .req_dir(1'b0),
    .req_dwell(req_dwell_s), .req_ready(req_ready_s), .abort(abort_s),
    .SD1(SD1_s), .SD2(SD2_s), .busy(busy_s), .done(done_s),
    .done_dir(done_dir_s), .aborted(aborted_s)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural detector: 11 -> 01 -> 00 -> 10 -> 11 is inc,
  // 11 -> 10 -> 00 -> 01 -> 11 is dec; any other step breaks until 11.
  int         ds = 0;
  logic [1:0] prev_p = 2'b11;
  always @(posedge clk) begin
    logic [1:0] p;
    p = {SD1, SD2};
    if (p !== prev_p) begin
      if (p == 2'b11) begin
        if (ds == 3) inc_cnt++;
        if (ds == 6) dec_cnt++;
        ds = 0;
      end else begin
        case (ds)
          0:       ds = (p == 2'b01) ? 1 : (p == 2'b10) ? 4 : 7;
          1:       ds = (p == 2'b00) ? 2 : 7;
          2:       ds = (p == 2'b10) ? 3 : 7;
          4:       ds = (p == 2'b00) ? 5 : 7;
          5:       ds = (p == 2'b01) ? 6 : 7;
          default: ds = 7;
        endcase
      end
      prev_p = p;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pat(input logic dir, input int ph);
    case (ph)
      1:       return dir ? 2'b10 : 2'b01;
      2:       return 2'b00;
      3:       return dir ? 2'b01 : 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Inputs are already set so that an accept happens on the next edge.
  // Checks every cycle of the sequence and stops in the done cycle.
  task automatic do_seq(input logic dir, input int d, input bit hold, input bit poke);
    int step;
    step = 0;
    tick();
    if (!hold) req_valid = 1'b0;
    p1_start = cyc;
    for (int ph = 1; ph <= 3; ph++) begin
      for (int i = 0; i <= d; i++) begin
        chk("phase_sd", 16'({SD1, SD2}), 16'(pat(dir, ph)));
        chk("phase_status", 16'({busy, req_ready, done, aborted}), 16'b1000);
        if (poke && step == 1) begin req_valid = 1'b1; req_dir = ~dir; end
        if (poke && step == 2) req_valid = 1'b0;
        step++;
        tick();
      end
    end
    for (int i = 0; i < GAP_CYC; i++) begin
      chk("gap_sd", 16'({SD1, SD2}), 16'b11);
      chk("gap_status", 16'({busy, req_ready, done, aborted}), 16'b1000);
      tick();
    end
    chk("done_sd", 16'({SD1, SD2}), 16'b11);
    chk("done_flags", 16'({busy, req_ready, done, done_dir, aborted}),
        16'({1'b0, 1'b1, 1'b1, dir, 1'b0}));
  endtask

  initial begin
    int first;
    int n;
    int inc0, dec0;
    rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_dwell = '0; abort = 1'b0;
    req_valid_s = 1'b0; req_dwell_s = '0; abort_s = 1'b0;
    tick(); tick();

    // Reset values
    chk("reset_out", 16'({SD1, SD2, req_ready, busy, done, done_dir, aborted}), 16'b1110000);
    rst = 1'b0;
    tick();
    chk("idle_out", 16'({SD1, SD2, req_ready, busy, done, done_dir, aborted}), 16'b1110000);

    // Enter, d=0
    req_valid = 1'b1; req_dir = 1'b0; req_dwell = 16'd0;
    do_seq(1'b0, 0, 1'b0, 1'b0);
    tick();
    chk("enter_done_clear", 16'(done), 16'd0);
    chk("enter_inc", 16'(inc_cnt), 16'd1);
    chk("enter_dec", 16'(dec_cnt), 16'd0);

    // Exit, d=3
    req_valid = 1'b1; req_dir = 1'b1; req_dwell = 16'd3;
    do_seq(1'b1, 3, 1'b0, 1'b0);
    tick();
    chk("exit_inc", 16'(inc_cnt), 16'd1);
    chk("exit_dec", 16'(dec_cnt), 16'd1);

    // Back-to-back with req_valid held high: enter then exit, d=1
    req_valid = 1'b1; req_dir = 1'b0; req_dwell = 16'd1;
    do_seq(1'b0, 1, 1'b1, 1'b0);
    first = p1_start;
    req_dir = 1'b1;
    do_seq(1'b1, 1, 1'b0, 1'b0);
    chk("b2b_spacing", 16'(p1_start - first), 16'd11);
    tick();
    chk("b2b_inc", 16'(inc_cnt), 16'd2);
    chk("b2b_dec", 16'(dec_cnt), 16'd2);

    // Abort in P2 of an enter, d=2
    inc0 = inc_cnt; dec0 = dec_cnt;
    req_valid = 1'b1; req_dir = 1'b0; req_dwell = 16'd2;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();          // 3 P1 cycles, now 2nd P2 cycle
    chk("abort_in_p2", 16'({SD1, SD2}), 16'b00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_sd", 16'({SD1, SD2}), 16'b11);
    chk("abort_gap_status", 16'({busy, done, aborted}), 16'b100);
    for (int i = 0; i < GAP_CYC; i++) begin
      if (i > 0) chk("abort_gap_hold", 16'({SD1, SD2, busy, aborted}), 16'b1110);
      abort = 1'b1;                              // ignored in GAP
      tick();
      abort = 1'b0;
    end
    chk("abort_pulse", 16'({busy, req_ready, done, aborted}), 16'b0101);
    tick();
    chk("abort_pulse_end", 16'({done, aborted}), 16'b00);
    chk("abort_inc", 16'(inc_cnt), 16'(inc0));
    chk("abort_dec", 16'(dec_cnt), 16'(dec0));

    // Request while busy is dropped; no extra sequence afterwards
    req_valid = 1'b1; req_dir = 1'b0; req_dwell = 16'd1;
    do_seq(1'b0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_extra_seq", 16'({SD1, SD2, busy}), 16'b110);
    end

    // Reset in P3
    req_valid = 1'b1; req_dir = 1'b1; req_dwell = 16'd2;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_in_p3", 16'({SD1, SD2}), 16'(pat(1'b1, 3)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_values", 16'({SD1, SD2, req_ready, busy, done, done_dir, aborted}), 16'b1110000);
    for (int i = 0; i < 3 * 3 + GAP_CYC + 2; i++) begin
      tick();
      chk("rst_no_done", 16'({busy, done, aborted}), 16'b000);
    end

    // Max dwell on the 4-bit instance: every phase exactly 16 cycles
    req_valid_s = 1'b1; req_dwell_s = 4'd15;
    tick();
    req_valid_s = 1'b0;
    for (int ph = 1; ph <= 3; ph++) begin
      n = 0;
      while ({SD1_s, SD2_s} == pat(1'b0, ph) && n < 40) begin n++; tick(); end
      chk("maxdwell_phase_len", 16'(n), 16'd16);
    end
    n = 0;
    while (busy_s && n < 40) begin n++; tick(); end
    chk("maxdwell_gap_len", 16'(n), 16'(GAP_CYC));
    chk("maxdwell_done", 16'({done_s, done_dir_s, req_ready_s}), 16'b101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_sequencer.md
# car_sequencer

Sensor-side stimulus generator for the parking-lot gate: on request it drives the two active-low gate sensors `SD1`/`SD2` through the exact four-phase pattern of one car entering or one car leaving. Each phase holds for a programmable dwell. It is the transmit end of the sensor protocol that the car detector decodes into `inc`/`dec`. It drives the detector in the board-level demo (switch/button front end) and in the system testbench.

## Interface
Parameters:
- `DWELL_W`, 16: width of the per-phase dwell count.
- `GAP_CYC`, 4: cycles both sensors are held high after phase 3 before completion. Legal range ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: a car-movement request is present.
- `req_dir` in 1: direction, 0 = enter, 1 = exit. Sampled only on accept.
- `req_dwell` in DWELL_W: each of phases 1–3 lasts `req_dwell`+1 cycles. Sampled only on accept.
- `req_ready` out 1: high only in IDLE.
- `abort` in 1: car backs out. Ignored in IDLE.
- `SD1` out 1: outer sensor, active-low (0 = car present).
- `SD2` out 1: inner sensor, active-low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a full sequence completes.
- `done_dir` out 1: direction of the completed sequence. Valid while `done`.
- `aborted` out 1: one-cycle pulse when a sequence ends through `abort`.

## Operation
- Reset values: `SD1`=1, `SD2`=1, `req_ready`=1, `busy`=0, `done`=0, `done_dir`=0, `aborted`=0, state IDLE.
- All outputs are registered. `rst` takes priority over every other input, in every state.
- Accept: `req_valid && req_ready` at a rising edge. On accept, latch `dir_q` from `req_dir` and `dwell_q` from `req_dwell`, load the dwell counter, and enter P1.
- States: IDLE, P1, P2, P3, GAP.
- Sensor levels for enter (`dir_q`=0), given as SD1/SD2:
  - P1 = 0/1
  - P2 = 0/0
  - P3 = 1/0
  - GAP and IDLE = 1/1
- Sensor levels for exit (`dir_q`=1): SD1 and SD2 are swapped in every state:
  - P1 = 1/0
  - P2 = 0/0
  - P3 = 0/1
- Dwell counter: down-counter of width DWELL_W. In P1–P3, advance to the next state when the counter is 0, reloading it with `dwell_q` (reload GAP_CYC-1 when advancing to GAP). Otherwise decrement.
- Arithmetic: `req_dwell` = 2^DWELL_W-1 is legal, with no overflow (phase length 2^DWELL_W). The counter never wraps below 0.
- GAP lasts GAP_CYC cycles. When the counter is 0 in GAP, go to IDLE and pulse `done` with `done_dir`=`dir_q`.
- Abort: when `abort`=1 in P1, P2 or P3, go to GAP on the next edge with both sensors high.
  - GAP still runs its full GAP_CYC cycles.
  - On leaving GAP, pulse `aborted` instead of `done`.
  - The sensor pattern is then incomplete, so the detector returns to its initial state without counting.
  - `abort` in GAP or IDLE has no effect.
- While busy, `req_valid` is ignored and no request is queued.
- The sensors never change between two legal levels except through one adjacent phase step. There is no cycle in which both sensors toggle at once, except on abort from P2 (0/0 to 1/1). That case is acceptable because the detector treats it as a break.

## Timing
- Accept at edge k. For dwell d, the enter outputs are:
  - P1 (SD1=0) over cycles k+1 … k+1+d.
  - P2 starts at k+2+d.
  - P3 starts at k+3+2d.
  - GAP starts at k+4+3d.
  - `done` and `req_ready` go high together at k+4+3d+GAP_CYC.
- Total busy length is 3(d+1)+GAP_CYC cycles.
- Back-to-back: with `req_valid` held high, the next accept occurs on the edge ending the `done` cycle. Minimum spacing between P1 starts is 3(d+1)+GAP_CYC+1 cycles.
- Abort latency: `abort` sampled at edge m gives SD1=SD2=1 from cycle m+1. `aborted` pulses at m+1+GAP_CYC.
- Reset mid-sequence: the cycle after the `rst` edge shows the reset values. No `done` or `aborted` pulse is produced for the cut sequence.

## Test plan
- Enter, d=0, GAP_CYC=4, accept at edge 10:
  - SD1/SD2 = 0/1 @11, 0/0 @12, 1/0 @13, 1/1 @14–17.
  - `done`=1, `done_dir`=0 @18.
  - The attached detector pulses `inc` exactly once and `dec` never.
- Exit, d=3, accept at edge 0:
  - SD1/SD2 = 1/0 @1–4, 0/0 @5–8, 0/1 @9–12, 1/1 @13–16.
  - `done`, `done_dir`=1 @17.
  - The detector pulses `dec` exactly once.
- Back-to-back, `req_valid` held high, enter then exit, d=1:
  - The second P1 starts 11 cycles after the first.
  - Exactly one `inc` then one `dec`. `req_ready` is high only in the `done` cycle.
- Abort in P2 of an enter, d=2:
  - Sensors are 1/1 the cycle after `abort`.
  - `aborted` pulses GAP_CYC cycles later. `done`, `inc` and `dec` stay 0.
- Request while busy, and `rst` asserted in P3:
  - The mid-sequence `req_valid` is dropped, with no extra sequence afterwards.
  - After `rst`, all outputs are at reset values the next cycle, with no `done`.
- Max dwell, DWELL_W=4, d=15:
  - Each phase lasts exactly 16 cycles and the counter does not wrap.
